// File: rtl/hmc_host_flit_tx.sv
// HMC host-side link transmitter: admits request packets against device token credit,
// stamps tail SEQ/FRP/RRP/RTC and emits a continuous FLIT stream with TRET and null FLITs.
module hmc_host_flit_tx #(
    parameter int unsigned TOKEN_W  = 8,
    parameter int unsigned INIT_RTC = 32
) (
    input  logic               FLITCLK,
    input  logic               P_RST_N,
    input  logic               link_active,
    input  logic [127:0]       req_flit,
    input  logic               req_valid,
    input  logic               req_sop,
    input  logic               req_eop,
    output logic               req_ready,
    input  logic               tok_ret_valid,
    input  logic [4:0]         tok_ret_cnt,
    input  logic               rtc_add_valid,
    input  logic [7:0]         rtc_add_cnt,
    input  logic [7:0]         rrp_in,
    output logic [127:0]       tx_flit,
    output logic               tx_valid,
    output logic [TOKEN_W-1:0] token_cnt,
    output logic [7:0]         rtc_pend,
    output logic               err_lng
);

    typedef enum logic [1:0] {ST_DOWN, ST_TRET, ST_RUN} state_t;

    // Token arithmetic is one bit wider than token_cnt + 31 so saturation needs no carry tricks.
    localparam int unsigned      SUM_W    = ((TOKEN_W > 5) ? TOKEN_W : 5) + 1;
    localparam logic [SUM_W-1:0] TOK_MAX  = SUM_W'((64'd1 << TOKEN_W) - 64'd1);
    localparam logic [63:0]      TRET_HDR = 64'h0000_0000_0000_0882;

    state_t           state;
    logic             in_pkt;
    logic [2:0]       seq;
    logic [7:0]       frp;
    logic [7:0]       frp_inc;
    logic [3:0]       lng_eff;
    logic             lng_zero;
    logic             up;
    logic             admit;
    logic             accept;
    logic             run_data;
    logic             send_tret;
    logic [4:0]       rtc_send;
    logic [4:0]       rtc_sent;
    logic [SUM_W-1:0] tok_sum;
    logic [SUM_W-1:0] tok_sat;
    logic [8:0]       rtc_sum;
    logic [7:0]       rtc_sat;
    logic [127:0]     data_flit;
    logic [127:0]     tret_flit;

    always_comb begin
        lng_zero  = (req_flit[10:7] == 4'd0);
        lng_eff   = lng_zero ? 4'd1 : req_flit[10:7];
        up        = link_active && (state != ST_DOWN);
        admit     = up && (state == ST_RUN) && !in_pkt && req_valid && req_sop
                    && (SUM_W'(token_cnt) >= SUM_W'(lng_eff));
        // While in_pkt the stream is always taken: forwarded when up, discarded when draining.
        req_ready = in_pkt || admit;
        accept    = req_valid && req_ready;
        run_data  = up && (state == ST_RUN) && accept;
        send_tret = up && ((state == ST_TRET) ||
                    ((state == ST_RUN) && !in_pkt && !admit && (rtc_pend != 8'd0)));
        rtc_send  = (rtc_pend > 8'd31) ? 5'd31 : rtc_pend[4:0];
        rtc_sent  = (send_tret || (run_data && req_eop)) ? rtc_send : 5'd0;
        frp_inc   = frp + 8'd1;

        tok_sum = SUM_W'(token_cnt)
                + (tok_ret_valid ? SUM_W'(tok_ret_cnt) : '0)
                - (admit ? SUM_W'(lng_eff) : '0);
        tok_sat = (tok_sum > TOK_MAX) ? TOK_MAX : tok_sum;
        rtc_sum = {1'b0, rtc_pend} + (rtc_add_valid ? {1'b0, rtc_add_cnt} : 9'd0)
                - {4'd0, rtc_sent};
        rtc_sat = (rtc_sum > 9'd255) ? 8'hFF : rtc_sum[7:0];

        data_flit = req_flit;
        if (req_eop) begin
            data_flit[71:64] = rrp_in;
            data_flit[79:72] = frp_inc;
            data_flit[82:80] = seq;
            data_flit[95:91] = rtc_send;
        end
        tret_flit = {32'd0, rtc_send, 8'd0, 3'd0, frp, rrp_in, TRET_HDR};
    end

    always_ff @(posedge FLITCLK or negedge P_RST_N) begin
        if (!P_RST_N) begin
            state     <= ST_DOWN;
            in_pkt    <= 1'b0;
            seq       <= '0;
            frp       <= '0;
            token_cnt <= '0;
            rtc_pend  <= '0;
            tx_flit   <= '0;
            tx_valid  <= 1'b0;
            err_lng   <= 1'b0;
        end else begin
            err_lng <= 1'b0;
            if (accept)
                in_pkt <= !req_eop;

            if (!up) begin
                tx_valid <= 1'b0;
                tx_flit  <= '0;
                if ((state == ST_DOWN) && link_active && !in_pkt) begin
                    state     <= ST_TRET;
                    rtc_pend  <= 8'(INIT_RTC);
                    seq       <= '0;
                    frp       <= '0;
                    token_cnt <= '0;
                end else begin
                    state <= ST_DOWN;
                end
            end else begin
                state     <= ST_RUN;
                tx_valid  <= 1'b1;
                token_cnt <= tok_sat[TOKEN_W-1:0];
                rtc_pend  <= rtc_sat;
                if (run_data) begin
                    tx_flit <= data_flit;
                    frp     <= frp_inc;
                    err_lng <= admit && lng_zero;
                    if (req_eop)
                        seq <= seq + 3'd1;
                end else if (send_tret) begin
                    tx_flit <= tret_flit;
                end else begin
                    tx_flit <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hmc_host_flit_tx.sv
// Randomized scoreboard bench for hmc_host_flit_tx: a packet-level reference model
// predicts every output cycle; a monitor pops and compares each registered output.
module tb_hmc_host_flit_tx;

    localparam int TOKEN_W  = 8;
    localparam int INIT_RTC = 32;
    localparam int TOK_MAX  = 255;

    logic               FLITCLK = 1'b0;
    logic               P_RST_N = 1'b0;
    logic               link_active = 1'b0;
    logic [127:0]       req_flit = '0;
    logic               req_valid = 1'b0;
    logic               req_sop = 1'b0;
    logic               req_eop = 1'b0;
    logic               req_ready;
    logic               tok_ret_valid = 1'b0;
    logic [4:0]         tok_ret_cnt = '0;
    logic               rtc_add_valid = 1'b0;
    logic [7:0]         rtc_add_cnt = '0;
    logic [7:0]         rrp_in = '0;
    logic [127:0]       tx_flit;
    logic               tx_valid;
    logic [TOKEN_W-1:0] token_cnt;
    logic [7:0]         rtc_pend;
    logic               err_lng;

    always #5 FLITCLK = ~FLITCLK;

    hmc_host_flit_tx #(.TOKEN_W(TOKEN_W), .INIT_RTC(INIT_RTC)) dut (
        .FLITCLK(FLITCLK), .P_RST_N(P_RST_N), .link_active(link_active),
        .req_flit(req_flit), .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop),
        .req_ready(req_ready), .tok_ret_valid(tok_ret_valid), .tok_ret_cnt(tok_ret_cnt),
        .rtc_add_valid(rtc_add_valid), .rtc_add_cnt(rtc_add_cnt), .rrp_in(rrp_in),
        .tx_flit(tx_flit), .tx_valid(tx_valid), .token_cnt(token_cnt),
        .rtc_pend(rtc_pend), .err_lng(err_lng)
    );

    typedef struct {
        logic         v;
        logic [127:0] f;
        int           tok;
        int           rtc;
        logic         err;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    bit   started = 0;

    // stimulus shadow (applied at the falling edge)
    bit           d_link = 0, d_valid = 0, d_sop = 0, d_eop = 0, d_tokv = 0, d_rtcv = 0;
    logic [127:0] d_flit = '0;
    logic [4:0]   d_tokc = '0;
    logic [7:0]   d_rtcc = '0;
    logic [7:0]   d_rrp = '0;

    // reference model state
    int m_tok = 0, m_rtc = 0, m_seq = 0, m_frp = 0;
    bit m_up = 0, m_tret_due = 0, m_inpkt = 0;

    logic [127:0] pkt[$];
    int           pidx = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [127:0] tret(int r);
        logic [127:0] t;
        t = '0;
        t[5:0]   = 6'h02;
        t[10:7]  = 4'd1;
        t[14:11] = 4'd1;
        t[71:64] = d_rrp;
        t[79:72] = 8'(m_frp);
        t[95:91] = 5'(r);
        return t;
    endfunction

    task automatic model_cycle(output bit rdy);
        exp_t e;
        int used, sent, lng, snd;
        bit was;
        logic [127:0] f;
        rdy = 0; e.v = 0; e.f = '0; e.err = 0;
        used = 0; sent = 0;
        snd = imin(m_rtc, 31);
        if (!m_up || !d_link) begin
            was = m_inpkt;
            rdy = m_inpkt;
            if (m_inpkt && d_valid && d_eop) m_inpkt = 0;
            if (!m_up && d_link && !was) begin
                m_up = 1; m_tret_due = 1;
                m_rtc = INIT_RTC; m_seq = 0; m_frp = 0; m_tok = 0;
            end else begin
                m_up = 0;
            end
        end else begin
            e.v = 1;
            if (m_tret_due) begin
                e.f = tret(snd); sent = snd; m_tret_due = 0;
            end else begin
                lng = (d_flit[10:7] == 4'd0) ? 1 : int'(d_flit[10:7]);
                if (m_inpkt) rdy = 1;
                else if (d_valid && d_sop && m_tok >= lng) begin
                    rdy = 1; used = lng; e.err = (d_flit[10:7] == 4'd0);
                end
                if (rdy && d_valid) begin
                    m_frp = (m_frp + 1) % 256;
                    f = d_flit;
                    if (d_eop) begin
                        f[71:64] = d_rrp;
                        f[79:72] = 8'(m_frp);
                        f[82:80] = 3'(m_seq);
                        f[95:91] = 5'(snd);
                        sent = snd;
                        m_seq = (m_seq + 1) % 8;
                        m_inpkt = 0;
                    end else begin
                        m_inpkt = 1;
                    end
                    e.f = f;
                end else if (!rdy && m_rtc > 0) begin
                    e.f = tret(snd); sent = snd;
                end
            end
            m_tok = imin(m_tok + (d_tokv ? int'(d_tokc) : 0) - used, TOK_MAX);
            m_rtc = imin(m_rtc + (d_rtcv ? int'(d_rtcc) : 0) - sent, 255);
        end
        e.tok = m_tok; e.rtc = m_rtc;
        expq.push_back(e);
    endtask

    task automatic new_pkt(input int lng_field);
        logic [127:0] f;
        int n;
        pkt.delete();
        pidx = 0;
        n = (lng_field == 0) ? 1 : lng_field;
        for (int i = 0; i < n; i++) begin
            f = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) f[10:7] = 4'(lng_field);
            pkt.push_back(f);
        end
    endtask

    task automatic run_cycle(input bit vld);
        bit rdy;
        if (pidx < pkt.size()) begin
            d_valid = vld; d_flit = pkt[pidx];
            d_sop = (pidx == 0); d_eop = (pidx == pkt.size() - 1);
        end else begin
            d_valid = 0; d_sop = 0; d_eop = 0; d_flit = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge FLITCLK);
        link_active = d_link; req_flit = d_flit; req_valid = d_valid;
        req_sop = d_sop; req_eop = d_eop; tok_ret_valid = d_tokv; tok_ret_cnt = d_tokc;
        rtc_add_valid = d_rtcv; rtc_add_cnt = d_rtcc; rrp_in = d_rrp;
        #1;
        model_cycle(rdy);
        chk("req_ready", 128'(req_ready), 128'(rdy));
        started = 1;
        if (d_valid && rdy) pidx++;
    endtask

    task automatic send_pkt(input int lng_field, input int budget);
        new_pkt(lng_field);
        for (int j = 0; j < budget && pidx < pkt.size(); j++) run_cycle(1);
        if (pidx < pkt.size()) chk("pkt_budget", 128'(pidx), 128'(pkt.size()));
    endtask

    always @(posedge FLITCLK) begin
        exp_t e;
        if (started) begin
            #1;
            if (expq.size() == 0) begin
                chk("queue_underrun", 128'(expq.size()), 128'd1);
            end else begin
                e = expq.pop_front();
                chk("tx_valid", 128'(tx_valid), 128'(e.v));
                if (e.v) chk("tx_flit", tx_flit, e.f);
                chk("token_cnt", 128'(token_cnt), 128'(e.tok));
                chk("rtc_pend", 128'(rtc_pend), 128'(e.rtc));
                chk("err_lng", 128'(err_lng), 128'(e.err));
            end
        end
    end

    initial begin
        repeat (3) @(posedge FLITCLK);
        #2;
        chk("rst_tx_valid", 128'(tx_valid), 128'd0);
        chk("rst_tx_flit", tx_flit, 128'd0);
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_token_cnt", 128'(token_cnt), 128'd0);
        chk("rst_rtc_pend", 128'(rtc_pend), 128'd0);
        chk("rst_err_lng", 128'(err_lng), 128'd0);
        @(negedge FLITCLK);
        P_RST_N = 1'b1;

        // link up, idle: TRET(31), TRET(1), then nulls
        d_link = 1;
        repeat (6) run_cycle(0);
        // four tokens, then a 3-FLIT packet and a 1-FLIT packet
        d_tokv = 1; d_tokc = 5'd4; run_cycle(0); d_tokv = 0;
        send_pkt(3, 6);
        send_pkt(1, 4);
        // insufficient tokens: hold, then admit after a single return
        d_tokv = 1; d_tokc = 5'd2; run_cycle(0); d_tokv = 0;
        new_pkt(3);
        repeat (4) run_cycle(1);
        d_tokv = 1; d_tokc = 5'd1; run_cycle(1); d_tokv = 0;
        for (int j = 0; j < 8 && pidx < pkt.size(); j++) run_cycle(1);
        // sequence wrap and FRP wrap
        d_tokv = 1; d_tokc = 5'd2;
        for (int k = 0; k < 9; k++) send_pkt(1, 4);
        d_tokc = 5'd31;
        for (int k = 0; k < 256; k++) send_pkt(1, 4);
        // link drop on the 2nd FLIT of a 4-FLIT packet, drain, relink
        new_pkt(4);
        for (int j = 0; j < 12 && pidx < pkt.size(); j++) begin
            if (pidx == 1) d_link = 0;
            run_cycle(1);
        end
        d_tokv = 0;
        run_cycle(0);
        d_link = 1;
        repeat (4) run_cycle(0);
        // LNG==0 with exactly one token
        d_tokv = 1; d_tokc = 5'd1; run_cycle(0); d_tokv = 0;
        send_pkt(0, 4);
        repeat (2) run_cycle(0);
        // saturation of both counters
        d_tokv = 1; d_tokc = 5'd31; d_rtcv = 1; d_rtcc = 8'd255;
        repeat (12) run_cycle(0);
        d_tokv = 0; d_rtcv = 0;
        repeat (3) run_cycle(0);

        // randomized traffic
        pkt.delete(); pidx = 0;
        for (int c = 0; c < 4000; c++) begin
            if (pidx >= pkt.size()) new_pkt($urandom_range(0, 9));
            if ($urandom_range(0, 299) == 0) d_link = !d_link;
            else if (!d_link && $urandom_range(0, 7) == 0) d_link = 1;
            d_tokv = ($urandom_range(0, 1) == 1);
            d_tokc = 5'($urandom_range(0, 31));
            d_rtcv = ($urandom_range(0, 9) == 0);
            d_rtcc = 8'($urandom_range(0, 255));
            d_rrp  = 8'($urandom);
            run_cycle($urandom_range(0, 4) != 0);
        end

        @(posedge FLITCLK);
        #3;
        chk("queue_drained", 128'(expq.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
